// File: rtl/lm32_dtlb_walker.sv
// DTLB hardware refill engine: on a DTLB miss, fetches one PTE from a linear
// page table over a Wishbone classic master port and issues a TLB update or a page fault.
module lm32_dtlb_walker #(
  parameter int page_size = 4096,
  parameter int timeout   = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [31:0] ptbr_i,
  input  logic        miss_i,
  input  logic [31:0] miss_addr_i,
  output logic [31:0] wb_adr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        tlb_update_o,
  output logic [31:0] tlb_vaddr_o,
  output logic [31:0] tlb_paddr_o,
  output logic        page_fault_o,
  output logic [31:0] fault_addr_o,
  output logic        busy_o
);

  localparam int OFF = $clog2(page_size);
  localparam int CW  = (timeout < 1) ? 1 : $clog2(timeout + 1);
  localparam logic [31:0] PG_MASK = ~(32'(page_size) - 32'd1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_UPDATE, S_FAULT, S_DRAIN} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_va;
  logic [31:0]   r_adr;
  logic          r_cyc;
  logic          r_update, r_fault, r_busy;
  logic [31:0]   r_vaddr, r_paddr, r_fault_addr;

  logic          w_timeout;
  logic [31:0]   w_vpn_ofs;
  logic [31:0]   w_pte_adr;

  assign w_timeout = (r_cnt == CW'(timeout));
  // Word offset of the PTE; the add wraps modulo 2^32 by construction.
  assign w_vpn_ofs = (miss_addr_i >> OFF) << 2;
  assign w_pte_adr = ptbr_i + w_vpn_ofs;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (miss_i && enable_i) w_next = S_REQ;
      S_REQ: begin
        if (wb_err_i)       w_next = S_FAULT;
        else if (wb_ack_i)  w_next = wb_dat_i[0] ? S_UPDATE : S_FAULT;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_UPDATE: w_next = S_DRAIN;
      S_FAULT:  w_next = S_DRAIN;
      // Hold off until the DTLB drops its pending miss, else we would re-walk it.
      S_DRAIN:  if (!miss_i) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
      r_va  <= '0;
      r_adr <= '0;
    end else if (r_state == S_IDLE && w_next == S_REQ) begin
      r_cnt <= '0;
      r_va  <= miss_addr_i;
      r_adr <= w_pte_adr;
    end else if (r_state == S_REQ && w_next == S_REQ) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they are flop outputs in the state they belong to.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cyc        <= 1'b0;
      r_update     <= 1'b0;
      r_fault      <= 1'b0;
      r_busy       <= 1'b0;
      r_vaddr      <= '0;
      r_paddr      <= '0;
      r_fault_addr <= '0;
    end else begin
      r_cyc    <= (w_next == S_REQ);
      r_update <= (w_next == S_UPDATE);
      r_fault  <= (w_next == S_FAULT);
      r_busy   <= (w_next != S_IDLE);
      if (r_state == S_REQ && w_next == S_UPDATE) begin
        r_vaddr <= r_va & PG_MASK;
        r_paddr <= wb_dat_i & PG_MASK;
      end
      if (r_state == S_REQ && w_next == S_FAULT)
        r_fault_addr <= r_va;
    end
  end

  assign wb_adr_o     = r_adr;
  assign wb_cyc_o     = r_cyc;
  assign wb_stb_o     = r_cyc;
  assign wb_we_o      = 1'b0;
  assign wb_sel_o     = 4'b1111;
  assign tlb_update_o = r_update;
  assign tlb_vaddr_o  = r_vaddr;
  assign tlb_paddr_o  = r_paddr;
  assign page_fault_o = r_fault;
  assign fault_addr_o = r_fault_addr;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_lm32_dtlb_walker.sv
// Bench for lm32_dtlb_walker: directed and randomized walks against a Wishbone
// slave model, checked with a page-table reference model.
module tb_lm32_dtlb_walker;
  localparam int PAGE = 4096;
  localparam int TMO  = 255;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        enable_i = 1'b0;
  logic [31:0] ptbr_i = '0;
  logic        miss_i = 1'b0;
  logic [31:0] miss_addr_i = '0;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        tlb_update_o;
  logic [31:0] tlb_vaddr_o, tlb_paddr_o;
  logic        page_fault_o;
  logic [31:0] fault_addr_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  // slave config: mode 0 = ack, 1 = err+ack together, 2 = silent
  int          s_mode = 0;
  int          s_waits = 0;
  int          s_cnt = 0;
  logic [31:0] s_dat = '0;
  int          n_bus = 0;
  logic [31:0] last_fault = '0;

  lm32_dtlb_walker #(.page_size(PAGE), .timeout(TMO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i), .ptbr_i(ptbr_i),
    .miss_i(miss_i), .miss_addr_i(miss_addr_i),
    .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .tlb_update_o(tlb_update_o), .tlb_vaddr_o(tlb_vaddr_o), .tlb_paddr_o(tlb_paddr_o),
    .page_fault_o(page_fault_o), .fault_addr_o(fault_addr_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    if (wb_cyc_o && wb_stb_o) begin
      if (s_mode != 2 && s_cnt == s_waits) begin
        wb_ack_i = 1'b1;
        wb_err_i = (s_mode == 1);
        wb_dat_i = s_dat;
        s_cnt = 0;
      end else s_cnt++;
    end else s_cnt = 0;
  end

  always @(posedge wb_cyc_o) n_bus++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic walk(input logic [31:0] ptbr, input logic [31:0] va, input logic [31:0] pte,
                      input int mode, input int waits, input int hold, input bit drop_en);
    logic [63:0] t;
    logic [31:0] exp_adr;
    bit          exp_up;
    int          exp_lat, lat, nup, nflt, bus0, nbusy;
    t       = {32'b0, ptbr} + 64'(va / PAGE) * 64'd4;
    exp_adr = t[31:0];
    exp_up  = (mode == 0) && pte[0];
    exp_lat = (mode == 2) ? TMO + 2 : waits + 2;
    s_mode = mode; s_waits = waits; s_dat = pte;
    bus0 = n_bus;
    @(negedge clk_i);
    ptbr_i = ptbr; miss_addr_i = va; miss_i = 1'b1; enable_i = 1'b1;
    @(posedge clk_i); #1;
    check("stb_on_trigger", 32'(wb_stb_o), 32'd1);
    check("pte_adr", wb_adr_o, exp_adr);
    if (drop_en) enable_i = 1'b0;
    lat = 1;
    while (!(tlb_update_o || page_fault_o) && lat < TMO + 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("update_pulse", 32'(tlb_update_o), 32'(exp_up));
    check("fault_pulse", 32'(page_fault_o), 32'(!exp_up));
    check("cyc_dropped", 32'(wb_cyc_o), 32'd0);
    if (exp_up) begin
      check("vaddr", tlb_vaddr_o, (va / PAGE) * PAGE);
      check("paddr", tlb_paddr_o, (pte / PAGE) * PAGE);
    end else last_fault = va;
    check("fault_addr", fault_addr_o, last_fault);
    nup = 0; nflt = 0; nbusy = 0;
    repeat (hold) begin
      @(posedge clk_i); #1;
      nup += int'(tlb_update_o); nflt += int'(page_fault_o); nbusy += int'(busy_o);
    end
    check("extra_pulses", 32'(nup + nflt), 32'd0);
    check("busy_in_drain", 32'(nbusy), 32'(hold));
    @(negedge clk_i); miss_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("idle_after_drain", 32'(busy_o), 32'd0);
    check("one_bus_cycle", 32'(n_bus - bus0), 32'd1);
  endtask

  initial begin
    int bus0, nbad;
    #1;
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_vaddr", tlb_vaddr_o, 32'd0);
    check("rst_paddr", tlb_paddr_o, 32'd0);
    check("rst_fault_addr", fault_addr_o, 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("we_sel", {27'd0, wb_we_o, wb_sel_o}, 32'h0000_000F);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    // valid PTE, 3 wait states
    walk(32'h0010_0000, 32'h0000_3ABC, 32'h0004_5001, 0, 3, 2, 0);
    // invalid PTE
    walk(32'h0010_0000, 32'h0000_3ABC, 32'h0004_5000, 0, 3, 2, 0);
    // err and ack together
    walk(32'h0010_0000, 32'h0000_7123, 32'h0004_5001, 1, 1, 1, 0);
    // silent slave -> timeout
    walk(32'h0020_0000, 32'h1234_5678, 32'h0000_0001, 2, 0, 1, 0);
    // zero-wait slave, long drain with miss held, enable dropped mid-walk
    walk(32'h0030_0000, 32'hABCD_E000, 32'h8765_4321, 0, 0, 20, 1);
    // address wrap
    walk(32'hFFFF_FFF0, 32'h0000_5000, 32'h0000_2001, 0, 0, 1, 0);

    for (int i = 0; i < 16; i++)
      walk($urandom & 32'hFFFF_FFFC, $urandom, $urandom, int'($urandom_range(0, 1)),
           int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));

    // enable low: miss must not start a walk
    bus0 = n_bus;
    @(negedge clk_i); enable_i = 1'b0; miss_i = 1'b1; miss_addr_i = 32'h0000_9000;
    nbad = 0;
    repeat (10) begin @(posedge clk_i); #1; nbad += int'(busy_o) + int'(wb_cyc_o); end
    check("disabled_no_walk", 32'(nbad + n_bus - bus0), 32'd0);
    miss_i = 1'b0;

    // async reset during REQ
    s_mode = 2;
    @(negedge clk_i); enable_i = 1'b1; miss_i = 1'b1; ptbr_i = 32'h0040_0000;
    repeat (3) @(posedge clk_i);
    #1;
    check("cyc_before_rst", 32'(wb_cyc_o), 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_async_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_async_stb", 32'(wb_stb_o), 32'd0);
    check("rst_async_busy", 32'(busy_o), 32'd0);
    check("rst_async_pulses", 32'(tlb_update_o) + 32'(page_fault_o), 32'd0);
    miss_i = 1'b0;
    @(negedge clk_i); rst_n_i = 1'b1;
    last_fault = '0;
    nbad = 0;
    repeat (5) begin
      @(posedge clk_i); #1;
      nbad += int'(busy_o) + int'(wb_cyc_o) + int'(tlb_update_o) + int'(page_fault_o);
    end
    check("idle_after_rst", 32'(nbad), 32'd0);
    check("fault_addr_cleared", fault_addr_o, last_fault);

    // walk works again after reset
    walk(32'h0050_0000, 32'h0000_1FFF, 32'hFFFF_F001, 0, 2, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
